coprocessor_gpu_regbank: RTL

- Parametrised successor of the CPU/GPU coprocessor register block; two bus ports (port 0 = CPU, port 1 = GPU) share one register bank.
- Adds a command FIFO (CPU pushes, GPU pops), masked write-1-to-clear interrupts and a frame-synchronised VGA offset shadow.
- Sits between the two cores' memory-mapped coprocessor windows and the VGA scan-out block.

---
 rtl/coprocessor_gpu_regbank_pkg.sv | 19 +
 rtl/coprocessor_gpu_regbank_if.sv | 15 +
 rtl/coprocessor_gpu_regbank_cmd_fifo.sv | 45 ++++
 rtl/coprocessor_gpu_regbank.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/coprocessor_gpu_regbank_pkg.sv
// Shared constants for the CPU/GPU coprocessor register bank: register map and interrupt bit positions.
package cpg_pkg;

  localparam int unsigned CPG_ADDR_VGA_OFFSET = 0;
  localparam int unsigned CPG_ADDR_PORT_ID    = 1;
  localparam int unsigned CPG_ADDR_INT_STATUS = 2;
  localparam int unsigned CPG_ADDR_CMD        = 3;
  localparam int unsigned CPG_ADDR_FRAME_CNT  = 4;
  localparam int unsigned CPG_ADDR_INT_ENABLE = 5;
  localparam int unsigned CPG_ADDR_INT_SET    = 6;
  localparam int unsigned CPG_ADDR_CMD_LEVEL  = 7;

  localparam int unsigned CPG_INT_FRAME     = 0;
  localparam int unsigned CPG_INT_CMD_PUSH  = 1;
  localparam int unsigned CPG_INT_CMD_DRAIN = 2;
  localparam int unsigned CPG_INT_SW_LO     = 8;
  localparam int unsigned CPG_INT_SW_HI     = 15;

endpackage

// File: rtl/coprocessor_gpu_regbank_if.sv
// One memory-mapped coprocessor bus port; read data and ready are combinational from the slave.
interface coprocessor_gpu_regbank_if #(
  parameter int unsigned DW = 48,
  parameter int unsigned AW = 20
);
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          data_sel;
  logic          data_we;
  logic          data_ready;

  modport master (output addr, data_in, data_sel, data_we, input data_out, data_ready);
  modport slave  (input addr, data_in, data_sel, data_we, output data_out, data_ready);
endinterface

// File: rtl/coprocessor_gpu_regbank_cmd_fifo.sv
// Synchronous command FIFO; the caller guarantees push only when not full and pop only when not empty.
module cpg_cmd_fifo #(
  parameter int unsigned DW    = 48,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign head_c  = mem[rd_ptr];
  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == CW'(0));

  // Storage is not reset; only pointers and occupancy are.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/coprocessor_gpu_regbank.sv
// Dual-port CPU/GPU register bank with command FIFO, masked W1C interrupts and VGA offset.
// Define CPG_SHADOW_OFFSET_EN to make VGA_OFFSET writes frame-synchronised through a shadow register.
module coprocessor_gpu_regbank
  import cpg_pkg::*;
#(
  parameter int unsigned DW        = 48,
  parameter int unsigned AW        = 20,
  parameter int unsigned CMD_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  coprocessor_gpu_regbank_if.slave bus_0,
  coprocessor_gpu_regbank_if.slave bus_1,
  input  logic                    vga_offset_sel,
  output logic [DW-1:0]           vga_offset,
  output logic [DW-1:0]           interrupt
);

  localparam int unsigned CW = $clog2(CMD_DEPTH) + 1;
  localparam logic [DW-1:0] SW_MASK = DW'(16'hFF00);

  logic [AW-1:0] bus_addr  [2];
  logic [DW-1:0] bus_wdata [2];
  logic [DW-1:0] rdata     [2];
  logic [1:0]    sel, we, ready;

  assign bus_addr[0]  = bus_0.addr;
  assign bus_addr[1]  = bus_1.addr;
  assign bus_wdata[0] = bus_0.data_in;
  assign bus_wdata[1] = bus_1.data_in;
  assign sel = {bus_1.data_sel, bus_0.data_sel};
  assign we  = {bus_1.data_we,  bus_0.data_we};
  assign bus_0.data_out   = rdata[0];
  assign bus_1.data_out   = rdata[1];
  assign bus_0.data_ready = ready[0];
  assign bus_1.data_ready = ready[1];

  logic          vga_sel_q;
  logic          tick;
  logic [DW-1:0] frame_cnt_q, int_status_q, int_enable_q;
  logic [DW-1:0] status_nxt, enable_nxt, int_clr, int_set, off_wr_data, off_rd;
  logic          off_wr;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0] fifo_wdata, fifo_head;
  logic [CW-1:0] fifo_count;
  logic [1:0]    push_req, pop_req, push_gnt, pop_gnt;
  logic [1:0]    wr_off, wr_en, wr_clr, wr_set;

  assign tick = vga_offset_sel & ~vga_sel_q;

  // Decode and arbitration: port 0 has priority on the FIFO, port 1 wins plain register writes.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      push_req[p] = sel[p] & we[p]  & (bus_addr[p] == AW'(CPG_ADDR_CMD));
      pop_req[p]  = sel[p] & ~we[p] & (bus_addr[p] == AW'(CPG_ADDR_CMD));
      wr_off[p]   = sel[p] & we[p]  & (bus_addr[p] == AW'(CPG_ADDR_VGA_OFFSET));
      wr_en[p]    = sel[p] & we[p]  & (bus_addr[p] == AW'(CPG_ADDR_INT_ENABLE));
      wr_clr[p]   = sel[p] & we[p]  & (bus_addr[p] == AW'(CPG_ADDR_INT_STATUS));
      wr_set[p]   = sel[p] & we[p]  & (bus_addr[p] == AW'(CPG_ADDR_INT_SET));
    end
    push_gnt[0] = push_req[0] & ~fifo_full;
    push_gnt[1] = push_req[1] & ~push_req[0] & ~fifo_full;
    pop_gnt[0]  = pop_req[0] & ~fifo_empty;
    pop_gnt[1]  = pop_req[1] & ~pop_req[0] & ~fifo_empty;
    for (int p = 0; p < 2; p++) begin
      ready[p] = ~(push_req[p] & ~push_gnt[p]) & ~(pop_req[p] & ~pop_gnt[p]);
    end
    fifo_push  = |push_gnt;
    fifo_pop   = |pop_gnt;
    fifo_wdata = push_gnt[0] ? bus_wdata[0] : bus_wdata[1];
  end

  // Next register values; interrupt sets override same-cycle clears.
  always_comb begin
    off_wr      = |wr_off;
    off_wr_data = wr_off[1] ? bus_wdata[1] : bus_wdata[0];
    enable_nxt  = int_enable_q;
    if (wr_en[0]) enable_nxt = bus_wdata[0];
    if (wr_en[1]) enable_nxt = bus_wdata[1];
    int_clr = (wr_clr[0] ? bus_wdata[0] : '0) | (wr_clr[1] ? bus_wdata[1] : '0);
    int_set = '0;
    int_set[CPG_INT_FRAME]     = tick;
    int_set[CPG_INT_CMD_PUSH]  = fifo_push & fifo_empty;
    int_set[CPG_INT_CMD_DRAIN] = fifo_pop & ~fifo_push & (fifo_count == CW'(1));
    if (wr_set[0]) int_set = int_set | (bus_wdata[0] & SW_MASK);
    if (wr_set[1]) int_set = int_set | (bus_wdata[1] & SW_MASK);
    status_nxt = (int_status_q & ~int_clr) | int_set;
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = '0;
      case (bus_addr[p])
        AW'(CPG_ADDR_VGA_OFFSET): rdata[p] = off_rd;
        AW'(CPG_ADDR_PORT_ID):    rdata[p] = DW'(p);
        AW'(CPG_ADDR_INT_STATUS): rdata[p] = int_status_q;
        AW'(CPG_ADDR_CMD):        rdata[p] = fifo_empty ? '0 : fifo_head;
        AW'(CPG_ADDR_FRAME_CNT):  rdata[p] = frame_cnt_q;
        AW'(CPG_ADDR_INT_ENABLE): rdata[p] = int_enable_q;
        AW'(CPG_ADDR_CMD_LEVEL):  rdata[p] = DW'(fifo_count);
        default:                  rdata[p] = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_sel_q    <= 1'b0;
      frame_cnt_q  <= '0;
      int_status_q <= '0;
      int_enable_q <= '0;
      interrupt    <= '0;
    end else begin
      vga_sel_q    <= vga_offset_sel;
      if (tick) frame_cnt_q <= frame_cnt_q + DW'(1);
      int_status_q <= status_nxt;
      int_enable_q <= enable_nxt;
      interrupt    <= int_status_q & int_enable_q;
    end
  end

`ifdef CPG_SHADOW_OFFSET_EN
  logic [DW-1:0] shadow_q;
  assign off_rd = shadow_q;

  // A tick publishes the shadow as it stood before any coinciding write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q   <= '0;
      vga_offset <= '0;
    end else begin
      if (off_wr) shadow_q   <= off_wr_data;
      if (tick)   vga_offset <= shadow_q;
    end
  end
`else
  assign off_rd = vga_offset;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        vga_offset <= '0;
    else if (off_wr) vga_offset <= off_wr_data;
  end
`endif

  cpg_cmd_fifo #(.DW(DW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (fifo_wdata),
    .head_c  (fifo_head),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count   (fifo_count)
  );

endmodule
